// File: rtl/bus_master_arbiter.sv
// Round-robin arbiter sharing one bus master port among NREQ requesters, one transaction at a time.
// Optional WAIT-state timeout abort is enabled by defining BMA_TIMEOUT_EN.
module bus_master_arbiter #(
    parameter int NREQ       = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 4095
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            req_mode,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       err,
    output logic                       busy,
    output logic [1:0]                 fsm_state,
    output logic [ADDR_WIDTH-1:0]      m_addr,
    output logic [DATA_WIDTH-1:0]      m_wdata,
    output logic                       m_mode,
    output logic                       m_valid,
    input  logic                       m_ready,
    input  logic [DATA_WIDTH-1:0]      m_rdata,
    input  logic                       s_ready
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("bus_master_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
    end

    // Handshake: m_valid is asserted for exactly two cycles per transaction, after
    // which the arbiter waits in WAIT until m_ready is seen high on a clock edge.
    // m_addr/m_wdata/m_mode stay stable from the grant until the return to IDLE.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   cur;
    logic            issue_cnt;
    logic            found;
    logic [IW-1:0]   win;
    logic [IW-1:0]   next_ptr;
    int              idx;

`ifdef BMA_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]   wait_cnt;
`endif

    // Search from ptr upward with wrap; first requesting index wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    assign next_ptr  = (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_IDLE;
            ptr       <= '0;
            cur       <= '0;
            issue_cnt <= 1'b0;
            gnt       <= '0;
            done      <= '0;
            rdata     <= '0;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_mode    <= 1'b0;
            m_valid   <= 1'b0;
`ifdef BMA_TIMEOUT_EN
            err       <= 1'b0;
            wait_cnt  <= '0;
`endif
        end else begin
            gnt  <= '0;
            done <= '0;
`ifdef BMA_TIMEOUT_EN
            err  <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (found && s_ready) begin
                        m_addr    <= req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
                        m_wdata   <= req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
                        m_mode    <= req_mode[win];
                        m_valid   <= 1'b1;
                        gnt       <= NREQ'(1) << win;
                        cur       <= win;
                        ptr       <= next_ptr;
                        issue_cnt <= 1'b0;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issue_cnt) begin
                        m_valid  <= 1'b0;
                        state    <= S_WAIT;
`ifdef BMA_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end else begin
                        issue_cnt <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (m_ready) begin
                        // Writes return no data, so rdata keeps the last read value.
                        if (!m_mode) begin
                            rdata <= m_rdata;
                        end
                        done  <= NREQ'(1) << cur;
                        state <= S_FIN;
`ifdef BMA_TIMEOUT_EN
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        done  <= NREQ'(1) << cur;
                        err   <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
`endif
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifndef BMA_TIMEOUT_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed testbench for bus_master_arbiter: reset, read, write, round robin,
// s_ready stall, reset mid-transaction and the WAIT timeout behaviour.
module tb_bus_master_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int TOUT = 16;

    logic                 clk;
    logic                 rstn;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_mode;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic [DW-1:0]        rdata;
    logic                 err;
    logic                 busy;
    logic [1:0]           fsm_state;
    logic [AW-1:0]        m_addr;
    logic [DW-1:0]        m_wdata;
    logic                 m_mode;
    logic                 m_valid;
    logic                 m_ready;
    logic [DW-1:0]        m_rdata;
    logic                 s_ready;

    int checks = 0;
    int errors = 0;

    bus_master_arbiter #(
        .NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TOUT)
    ) dut (
        .clk(clk), .rstn(rstn), .req(req), .req_mode(req_mode),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .rdata(rdata), .err(err), .busy(busy), .fsm_state(fsm_state),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_mode(m_mode), .m_valid(m_valid),
        .m_ready(m_ready), .m_rdata(m_rdata), .s_ready(s_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        req     = '0;
        m_ready = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; req = '0; req_mode = '0; req_addr = '0; req_wdata = '0;
        m_ready = 1'b0; m_rdata = '0; s_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0 || done !== 4'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: gnt=%b done=%b err=%b expected 0", gnt, done, err);
        end
        checks++;
        if (busy !== 1'b0 || fsm_state !== 2'd0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b state=%0d m_valid=%b expected 0", busy, fsm_state, m_valid);
        end
        checks++;
        if (m_addr !== 16'h0 || m_wdata !== 8'h0 || m_mode !== 1'b0 || rdata !== 8'h0) begin
            errors++;
            $display("FAIL reset_data: m_addr=%h m_wdata=%h m_mode=%b rdata=%h expected 0",
                     m_addr, m_wdata, m_mode, rdata);
        end
        rstn = 1'b1;
    endtask

    task automatic test_single_read();
        req_mode[0]     = 1'b0;
        req_addr[15:0]  = 16'h8001;
        req             = 4'b0001;
        tick();
        checks++;
        if (gnt !== 4'b0001 || m_valid !== 1'b1 || m_addr !== 16'h8001 || m_mode !== 1'b0) begin
            errors++;
            $display("FAIL read_grant: gnt=%b m_valid=%b m_addr=%h m_mode=%b expected 0001 1 8001 0",
                     gnt, m_valid, m_addr, m_mode);
        end
        req = '0;
        tick();
        checks++;
        if (m_valid !== 1'b1 || gnt !== 4'b0) begin
            errors++;
            $display("FAIL read_valid2: m_valid=%b gnt=%b expected 1 0000", m_valid, gnt);
        end
        tick();
        checks++;
        if (m_valid !== 1'b0 || fsm_state !== 2'd2) begin
            errors++;
            $display("FAIL read_wait_entry: m_valid=%b state=%0d expected 0 2", m_valid, fsm_state);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (done !== 4'b0 || m_addr !== 16'h8001) begin
                errors++;
                $display("FAIL read_wait_hold: done=%b m_addr=%h expected 0000 8001", done, m_addr);
            end
        end
        m_ready = 1'b1;
        m_rdata = 8'hA5;
        tick();
        m_ready = 1'b0;
        m_rdata = 8'h00;
        checks++;
        if (done !== 4'b0001 || rdata !== 8'hA5 || fsm_state !== 2'd3) begin
            errors++;
            $display("FAIL read_done: done=%b rdata=%h state=%0d expected 0001 a5 3", done, rdata, fsm_state);
        end
        tick();
        checks++;
        if (done !== 4'b0 || busy !== 1'b0 || rdata !== 8'hA5) begin
            errors++;
            $display("FAIL read_idle: done=%b busy=%b rdata=%h expected 0000 0 a5", done, busy, rdata);
        end
    endtask

    task automatic test_write();
        req_mode[2]      = 1'b1;
        req_addr[47:32]  = 16'h1234;
        req_wdata[23:16] = 8'h3C;
        req              = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0100 || m_mode !== 1'b1 || m_wdata !== 8'h3C || m_addr !== 16'h1234) begin
            errors++;
            $display("FAIL write_grant: gnt=%b m_mode=%b m_wdata=%h m_addr=%h expected 0100 1 3c 1234",
                     gnt, m_mode, m_wdata, m_addr);
        end
        req = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (m_mode !== 1'b1 || m_wdata !== 8'h3C || m_addr !== 16'h1234) begin
                errors++;
                $display("FAIL write_hold: m_mode=%b m_wdata=%h m_addr=%h expected 1 3c 1234",
                         m_mode, m_wdata, m_addr);
            end
        end
        m_ready = 1'b1;
        m_rdata = 8'h77;
        tick();
        m_ready = 1'b0;
        checks++;
        if (done !== 4'b0100 || rdata !== 8'hA5 || m_wdata !== 8'h3C) begin
            errors++;
            $display("FAIL write_done: done=%b rdata=%h m_wdata=%h expected 0100 a5 3c", done, rdata, m_wdata);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        int n = 0;
        int drained = 0;
        logic [3:0] exp_g;
        do_reset();
        req_mode = '0;
        req      = 4'b1111;
        m_ready  = 1'b1;
        for (int cyc = 1; cyc <= 30 && n < 5; cyc++) begin
            tick();
            checks++;
            if (gnt !== 4'b0 && done !== 4'b0) begin
                errors++;
                $display("FAIL rr_overlap: gnt=%b done=%b expected not both set", gnt, done);
            end
            if (gnt !== 4'b0) begin
                exp_g = 4'b0001 << order[n];
                checks++;
                if (gnt !== exp_g || cyc != 1 + 5 * n) begin
                    errors++;
                    $display("FAIL rr_order: grant %0d gnt=%b at cycle %0d expected %b at cycle %0d",
                             n, gnt, cyc, exp_g, 1 + 5 * n);
                end
                n++;
            end
        end
        req = '0;
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL rr_count: saw %0d grants expected 5", n);
        end
        for (int i = 0; i < 10 && drained == 0; i++) begin
            tick();
            if (busy === 1'b0) drained = 1;
        end
        m_ready = 1'b0;
        checks++;
        if (drained != 1) begin
            errors++;
            $display("FAIL rr_drain: busy=%b expected 0 within 10 cycles", busy);
        end
    endtask

    task automatic test_s_ready();
        s_ready = 1'b0;
        req     = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (gnt !== 4'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL sready_stall: gnt=%b busy=%b expected 0000 0", gnt, busy);
            end
        end
        s_ready = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL sready_grant: gnt=%b expected 0010", gnt);
        end
        req     = '0;
        m_ready = 1'b1;
        m_rdata = 8'h5A;
        tick();
        tick();
        tick();
        m_ready = 1'b0;
        checks++;
        if (done !== 4'b0010 || rdata !== 8'h5A) begin
            errors++;
            $display("FAIL sready_done: done=%b rdata=%h expected 0010 5a", done, rdata);
        end
        tick();
    endtask

    task automatic test_reset_in_wait();
        req = 4'b0010;
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL rstwait_grant: gnt=%b expected 0010", gnt);
        end
        req = '0;
        tick();
        tick();
        tick();
        rstn = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0 || m_addr !== 16'h0 || m_mode !== 1'b0 ||
            rdata !== 8'h0 || done !== 4'b0 || gnt !== 4'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL rstwait_outputs: busy=%b m_valid=%b m_addr=%h rdata=%h done=%b expected all 0",
                     busy, m_valid, m_addr, rdata, done);
        end
        rstn = 1'b1;
        tick();
        checks++;
        if (done !== 4'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstwait_nodone: done=%b busy=%b expected 0000 0", done, busy);
        end
        // ptr would be 2 without the reset, picking requester 2 instead of 0.
        req = 4'b0101;
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL rstwait_ptr: gnt=%b expected 0001", gnt);
        end
        req = '0;
        tick();
        tick();
    endtask

`ifdef BMA_TIMEOUT_EN
    task automatic test_timeout();
        m_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (done !== 4'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL timeout_early: WAIT cycle %0d done=%b err=%b expected 0000 0", i + 2, done, err);
            end
        end
        tick();
        checks++;
        if (done !== 4'b0001 || err !== 1'b1 || rdata !== 8'h00) begin
            errors++;
            $display("FAIL timeout_abort: done=%b err=%b rdata=%h expected 0001 1 00", done, err, rdata);
        end
        tick();
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_after: err=%b busy=%b expected 0 0", err, busy);
        end
    endtask
`else
    task automatic test_timeout();
        m_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (done !== 4'b0 || err !== 1'b0 || fsm_state !== 2'd2) begin
                errors++;
                $display("FAIL nowait_limit: done=%b err=%b state=%0d expected 0000 0 2", done, err, fsm_state);
            end
        end
        m_ready = 1'b1;
        m_rdata = 8'hC3;
        tick();
        m_ready = 1'b0;
        checks++;
        if (done !== 4'b0001 || err !== 1'b0 || rdata !== 8'hC3) begin
            errors++;
            $display("FAIL nowait_done: done=%b err=%b rdata=%h expected 0001 0 c3", done, err, rdata);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_round_robin();
        test_s_ready();
        test_reset_in_wait();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
